// File: rtl/trigger_seq.sv
// Multi-stage sequential trigger: matches samples against programmable stages,
// steps a trigger level, and raises a sticky run once a start stage fires.
module trigger_seq #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] data_input,
    input  logic             input_ready,
    input  logic             cfg_wr,
    input  logic [3:0]       cfg_sel,
    input  logic [1:0]       cfg_addr,
    input  logic [31:0]      cfg_data,
    input  logic             arm,
    output logic             run,
    output logic             armed,
    output logic [3:0]       level
);

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        DELAY,
        FIRED
    } state_t;

    state_t state;
    state_t stateNext;

    logic [WIDTH-1:0] maskReg  [STAGES];
    logic [WIDTH-1:0] valueReg [STAGES];
    logic [22:0]      cfgReg   [STAGES];

    logic [WIDTH-1:0] prevSample;
    logic             prevValid;

    logic [15:0] cnt;
    logic [15:0] cntNext;
    logic        startLatch;
    logic        startNext;
    logic [3:0]  levelNext;
    logic        runNext;

    logic [STAGES-1:0] hit;
    logic              hitAny;
    logic [15:0]       winDelay;
    logic              winStart;
    logic              doAct;
    logic              actStart;

    logic unusedCfg;
    assign unusedCfg = ^cfg_data[31:23];

    assign armed = (state == ARMED) || (state == DELAY);

    always_comb begin
        hit = '0;
        for (int i = 0; i < STAGES; i++) begin
            if (state == ARMED && input_ready && cfgReg[i][22] &&
                cfgReg[i][19:16] == level) begin
                if (cfgReg[i][21]) begin
                    hit[i] = prevValid &&
                        (((data_input ^ prevSample) & maskReg[i]) != '0);
                end else begin
                    hit[i] =
                        (((data_input ^ valueReg[i]) & maskReg[i]) == '0);
                end
            end
        end
    end

    // Walk downwards so the lowest matching index is the one left standing.
    always_comb begin
        hitAny   = 1'b0;
        winDelay = '0;
        winStart = 1'b0;
        for (int i = STAGES - 1; i >= 0; i--) begin
            if (hit[i]) begin
                hitAny   = 1'b1;
                winDelay = cfgReg[i][15:0];
                winStart = cfgReg[i][20];
            end
        end
    end

    always_comb begin
        stateNext = state;
        levelNext = level;
        cntNext   = cnt;
        startNext = startLatch;
        runNext   = run;
        doAct     = 1'b0;
        actStart  = 1'b0;
        if (arm) begin
            stateNext = ARMED;
            levelNext = '0;
            cntNext   = '0;
            startNext = 1'b0;
            runNext   = 1'b0;
        end else begin
            unique case (state)
                ARMED: begin
                    if (hitAny) begin
                        cntNext   = winDelay;
                        startNext = winStart;
                        if (winDelay == 16'd0) begin
                            doAct    = 1'b1;
                            actStart = winStart;
                        end else begin
                            stateNext = DELAY;
                        end
                    end
                end
                DELAY: begin
                    if (input_ready) begin
                        cntNext = cnt - 16'd1;
                        if (cnt == 16'd1) begin
                            doAct    = 1'b1;
                            actStart = startLatch;
                        end
                    end
                end
                default: ;
            endcase
            if (doAct) begin
                if (actStart) begin
                    runNext   = 1'b1;
                    stateNext = FIRED;
                end else begin
                    stateNext = ARMED;
                    if (level != 4'hF) begin
                        levelNext = level + 4'd1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            level      <= '0;
            cnt        <= '0;
            startLatch <= 1'b0;
            run        <= 1'b0;
        end else begin
            state      <= stateNext;
            level      <= levelNext;
            cnt        <= cntNext;
            startLatch <= startNext;
            run        <= runNext;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            prevSample <= '0;
            prevValid  <= 1'b0;
        end else if (arm) begin
            prevValid <= 1'b0;
        end else if (input_ready) begin
            prevSample <= data_input;
            prevValid  <= 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < STAGES; i++) begin
                maskReg[i]  <= '0;
                valueReg[i] <= '0;
                cfgReg[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < STAGES; i++) begin
                if (cfg_wr && cfg_sel == 4'(i)) begin
                    case (cfg_addr)
                        2'd0:    maskReg[i]  <= cfg_data[WIDTH-1:0];
                        2'd1:    valueReg[i] <= cfg_data[WIDTH-1:0];
                        2'd2:    cfgReg[i]   <= cfg_data[22:0];
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_trigger_seq.sv
// Scoreboard bench for trigger_seq: stimulus queues expected {run,armed,level},
// a monitor pops and compares after every clock edge.
module tb_trigger_seq;

    logic        clock;
    logic        reset_n;
    logic [31:0] data_input;
    logic        input_ready;
    logic        cfg_wr;
    logic [3:0]  cfg_sel;
    logic [1:0]  cfg_addr;
    logic [31:0] cfg_data;
    logic        arm;
    logic        run;
    logic        armed;
    logic [3:0]  level;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit         chk;
        logic [5:0] exp;
        string      name;
    } exp_t;

    exp_t sbq[$];

    trigger_seq #(.WIDTH(32), .STAGES(4)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .data_input (data_input),
        .input_ready(input_ready),
        .cfg_wr     (cfg_wr),
        .cfg_sel    (cfg_sel),
        .cfg_addr   (cfg_addr),
        .cfg_data   (cfg_data),
        .arm        (arm),
        .run        (run),
        .armed      (armed),
        .level      (level)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [5:0] ex(input logic r, input logic a,
                                      input logic [3:0] l);
        return {r, a, l};
    endfunction

    function automatic logic [31:0] cw(input logic [15:0] d,
                                       input logic [3:0] l, input logic st,
                                       input logic ed, input logic en);
        return {9'd0, en, ed, st, l, d};
    endfunction

    function automatic void check(input string n, input logic [5:0] act,
                                  input logic [5:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: {run,armed,level} actual=%b required=%b",
                     n, act, req);
        end
    endfunction

    task automatic drv(input logic a, input logic w, input logic [3:0] s,
                       input logic [1:0] ad, input logic [31:0] cd,
                       input logic [31:0] d, input logic r, input bit c,
                       input logic [5:0] e, input string n);
        exp_t it;
        @(negedge clock);
        arm         = a;
        cfg_wr      = w;
        cfg_sel     = s;
        cfg_addr    = ad;
        cfg_data    = cd;
        data_input  = d;
        input_ready = r;
        it.chk  = c;
        it.exp  = e;
        it.name = n;
        sbq.push_back(it);
    endtask

    task automatic wr(input logic [3:0] s, input logic [1:0] ad,
                      input logic [31:0] cd);
        drv(1'b0, 1'b1, s, ad, cd, 32'd0, 1'b0, 1'b0, 6'd0, "cfg");
    endtask

    task automatic doArm(input string n);
        drv(1'b1, 1'b0, 4'd0, 2'd0, 32'd0, 32'd0, 1'b0, 1'b1,
            ex(1'b0, 1'b1, 4'd0), n);
    endtask

    task automatic smp(input logic [31:0] d, input logic r,
                       input logic [5:0] e, input string n);
        drv(1'b0, 1'b0, 4'd0, 2'd0, 32'd0, d, r, 1'b1, e, n);
    endtask

    task automatic stage(input logic [3:0] s, input logic [31:0] m,
                         input logic [31:0] v, input logic [31:0] c);
        wr(s, 2'd0, m);
        wr(s, 2'd1, v);
        wr(s, 2'd2, c);
    endtask

    initial begin
        forever begin
            @(posedge clock);
            #1;
            if (sbq.size() != 0) begin
                exp_t it;
                it = sbq.pop_front();
                if (it.chk) check(it.name, {run, armed, level}, it.exp);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n     = 1'b0;
        data_input  = '0;
        input_ready = 1'b0;
        cfg_wr      = 1'b0;
        cfg_sel     = '0;
        cfg_addr    = '0;
        cfg_data    = '0;
        arm         = 1'b0;
        #1;
        check("reset", {run, armed, level}, ex(1'b0, 1'b0, 4'd0));
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        smp(32'h5A, 1'b1, ex(1'b0, 1'b0, 4'd0), "idle_sample");

        // single stage, D=0, start
        stage(4'd0, 32'hFF, 32'h5A, cw(16'd0, 4'd0, 1'b1, 1'b0, 1'b1));
        doArm("t1_arm");
        smp(32'h00, 1'b1, ex(1'b0, 1'b1, 4'd0), "t1_nomatch");
        smp(32'h5A, 1'b1, ex(1'b1, 1'b0, 4'd0), "t1_fire");
        smp(32'h00, 1'b0, ex(1'b1, 1'b0, 4'd0), "t1_sticky");

        // three-level sequence
        stage(4'd0, 32'hFF, 32'h11, cw(16'd0, 4'd0, 1'b0, 1'b0, 1'b1));
        stage(4'd1, 32'hFF, 32'h22, cw(16'd0, 4'd1, 1'b0, 1'b0, 1'b1));
        stage(4'd2, 32'hFF, 32'h33, cw(16'd0, 4'd2, 1'b1, 1'b0, 1'b1));
        doArm("t2_arm");
        smp(32'h22, 1'b1, ex(1'b0, 1'b1, 4'd0), "t2_early22");
        smp(32'h11, 1'b1, ex(1'b0, 1'b1, 4'd1), "t2_lvl1");
        smp(32'h33, 1'b1, ex(1'b0, 1'b1, 4'd1), "t2_early33");
        smp(32'h22, 1'b1, ex(1'b0, 1'b1, 4'd2), "t2_lvl2");
        smp(32'h33, 1'b1, ex(1'b1, 1'b0, 4'd2), "t2_fire");

        // delay of 3 samples with gaps
        wr(4'd1, 2'd2, 32'd0);
        wr(4'd2, 2'd2, 32'd0);
        stage(4'd0, 32'hFF, 32'h5A, cw(16'd3, 4'd0, 1'b1, 1'b0, 1'b1));
        doArm("t3_arm");
        smp(32'h5A, 1'b1, ex(1'b0, 1'b1, 4'd0), "t3_match");
        smp(32'h00, 1'b0, ex(1'b0, 1'b1, 4'd0), "t3_gap1");
        smp(32'h00, 1'b1, ex(1'b0, 1'b1, 4'd0), "t3_s1");
        smp(32'h00, 1'b0, ex(1'b0, 1'b1, 4'd0), "t3_gap2");
        smp(32'h00, 1'b1, ex(1'b0, 1'b1, 4'd0), "t3_s2");
        smp(32'h00, 1'b0, ex(1'b0, 1'b1, 4'd0), "t3_gap3");
        smp(32'h00, 1'b0, ex(1'b0, 1'b1, 4'd0), "t3_gap4");
        smp(32'h00, 1'b1, ex(1'b1, 1'b0, 4'd0), "t3_fire");

        // edge mode
        stage(4'd0, 32'h01, 32'h00, cw(16'd0, 4'd0, 1'b1, 1'b1, 1'b1));
        doArm("t4_arm");
        smp(32'h01, 1'b1, ex(1'b0, 1'b1, 4'd0), "t4_noprev");
        smp(32'h01, 1'b1, ex(1'b0, 1'b1, 4'd0), "t4_noedge");
        smp(32'h00, 1'b1, ex(1'b1, 1'b0, 4'd0), "t4_fire");

        // priority, then re-arm during delay
        stage(4'd0, 32'hFF, 32'h44, cw(16'd0, 4'd0, 1'b0, 1'b0, 1'b1));
        stage(4'd1, 32'hFF, 32'h44, cw(16'd0, 4'd0, 1'b1, 1'b0, 1'b1));
        stage(4'd2, 32'hFF, 32'h77, cw(16'd5, 4'd1, 1'b1, 1'b0, 1'b1));
        doArm("t5_arm");
        smp(32'h44, 1'b1, ex(1'b0, 1'b1, 4'd1), "t5_prio");
        smp(32'h44, 1'b1, ex(1'b0, 1'b1, 4'd1), "t5_lvl_gate");
        smp(32'h77, 1'b1, ex(1'b0, 1'b1, 4'd1), "t5_delay");
        smp(32'h00, 1'b1, ex(1'b0, 1'b1, 4'd1), "t5_cnt");
        doArm("t5_rearm");
        for (int i = 0; i < 5; i++) begin
            smp(32'h00, 1'b1, ex(1'b0, 1'b1, 4'd0), "t5_aborted");
        end

        // async reset in the middle of a delay
        wr(4'd2, 2'd2, 32'd0);
        stage(4'd0, 32'hFF, 32'h11, cw(16'd0, 4'd0, 1'b0, 1'b0, 1'b1));
        stage(4'd1, 32'hFF, 32'h5A, cw(16'd10, 4'd1, 1'b1, 1'b0, 1'b1));
        doArm("t6_arm");
        smp(32'h11, 1'b1, ex(1'b0, 1'b1, 4'd1), "t6_lvl1");
        smp(32'h5A, 1'b1, ex(1'b0, 1'b1, 4'd1), "t6_delay");
        smp(32'h00, 1'b0, ex(1'b0, 1'b1, 4'd1), "t6_hold");
        @(posedge clock);
        #3;
        reset_n = 1'b0;
        #1;
        check("t6_async_reset", {run, armed, level}, ex(1'b0, 1'b0, 4'd0));
        @(negedge clock);
        reset_n = 1'b1;
        doArm("t6_rearm");
        smp(32'h11, 1'b1, ex(1'b0, 1'b1, 4'd0), "t6_disabled0");
        smp(32'h5A, 1'b1, ex(1'b0, 1'b1, 4'd0), "t6_disabled1");
        smp(32'h00, 1'b0, ex(1'b0, 1'b1, 4'd0), "t6_quiet");

        for (int i = 0; i < 10 && sbq.size() != 0; i++) begin
            @(posedge clock);
            #2;
        end
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL drain: pending=%0d required=0", sbq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/trigger_seq.md
# trigger_seq

Parametrised multi-stage sequential trigger for the logic analyser core; the successor to the fixed 4-stage, 32-channel trigger. It sits between the input sampler and the capture controller. It compares each input sample against up to STAGES programmable stages, in either value or edge mode, and advances a global trigger level through the sequence. It asserts a sticky `run` once a stage marked "start" fires after its programmed sample delay.

## Interface
Parameters:
- WIDTH, 32, channel count (sample width), 1..32
- STAGES, 4, number of trigger stages, 1..16

Ports:
- clock  input  1  system clock, all logic on rising edge
- reset_n  input  1  asynchronous, active-low reset
- data_input  input  WIDTH  current sample
- input_ready  input  1  data_input valid this cycle
- cfg_wr  input  1  configuration write strobe
- cfg_sel  input  4  stage index; writes with cfg_sel >= STAGES are ignored
- cfg_addr  input  2  register select: 0 mask, 1 value, 2 config, 3 ignored
- cfg_data  input  32  write data; mask/value use bits [WIDTH-1:0]
- arm  input  1  synchronous start pulse
- run  output  1  capture start, sticky
- armed  output  1  trigger sequence in progress (ARMED or DELAY)
- level  output  4  current trigger level

## Operation
- Config word fields:
  - [15:0] delay D (samples)
  - [19:16] stage level L
  - [20] start
  - [21] edge mode
  - [22] enable
  - other bits ignored
- Stage i is eligible when enable=1, L == level, and the state is ARMED.
- Value-mode match: ((data_input ^ value) & mask) == 0 with input_ready=1. An all-zero mask therefore matches every valid sample.
- Edge-mode match: ((data_input ^ prev) & mask) != 0 with input_ready=1 and prev_valid=1.
  - prev is the last sample with input_ready=1; prev_valid is cleared on arm.
- If several stages match in the same cycle, the lowest index wins and the others are ignored.
- States:
  - IDLE -> ARMED: on arm.
  - ARMED -> on a winning match, load cnt=D, latch the winner's start bit, then:
    - if D == 0, act immediately;
    - otherwise go to DELAY.
  - DELAY: each input_ready decrements cnt; when a decrement reaches 0, act.
  - Act, start=1: run<=1, go to FIRED.
  - Act, start=0: level<=level+1 (saturates at 15), return to ARMED.
  - FIRED: holds until arm.
- arm from any state: state=ARMED, level=0, cnt=0, prev_valid=0. run is cleared on the same edge. Configuration is retained. arm has priority over a simultaneous match.
- Config writes are accepted in any state. They take effect for matches from the next cycle. A write does not disturb a delay already in progress.
- delay counter is 16 bits, unsigned; D=65535 waits 65535 further samples.
- Reset (reset_n=0), immediately and asynchronously:
  - state=IDLE, run=0, armed=0, level=0, cnt=0, prev_valid=0;
  - all mask/value/config registers cleared, so every stage is disabled.

## Timing
- Match to action, D=0: the sample valid in cycle t gives run=1 (or level+1) in cycle t+1.
- Match to action, D>0: action is visible in the cycle after the D-th input_ready following the matching sample.
  - Cycles with input_ready=0 do not count.
- armed is 1 in cycle t+1 after arm in cycle t.
- armed is 0 in IDLE and FIRED.
- run stays high until arm or reset; there is no glitch, because run is registered.
- prev updates on every input_ready cycle, including the matching sample.

## Test plan
- Single stage, D=0, start=1.
  - Stimulus: stage0 mask=0xFF, value=0x5A, L=0; arm; then samples 0x00, 0x5A.
  - Required: run=1 in the cycle after 0x5A; level=0; armed=0.
- Three-level sequence.
  - Stimulus: stages 0/1/2 at L=0/1/2, values 0x11/0x22/0x33, stage2 start=1.
  - Samples 0x22, 0x11, 0x33, 0x22, 0x33: level steps 0->1 after 0x11, 1->2 after 0x22; run=1 after the final 0x33.
  - Required: the first 0x22 and first 0x33 have no effect.
- Delay with gaps.
  - Stimulus: stage0 D=3, start=1; the match is followed by 3 samples interleaved with input_ready=0 cycles.
  - Required: run rises exactly the cycle after the 3rd sample.
- Edge mode.
  - Stimulus: stage0 edge mode, mask=0x01; arm; first sample 0x01, then 0x01, then 0x00.
  - Required: no match on the first sample (prev_valid=0) or the second; run=1 after 0x00.
- Priority and re-arm.
  - Stimulus: stages 0 and 1 both at L=0 match the same sample; stage0 start=0, stage1 start=1.
  - Required: level becomes 1 and run stays 0.
  - Then arm during DELAY: level=0, cnt aborted, run=0.
- Async reset mid-DELAY.
  - Stimulus: drop reset_n between clock edges.
  - Required: run/armed/level are 0 immediately; after release, a sample that previously matched does not fire, because stages are disabled.
